seg_result_scanner: RTL

// - Downstream display stage of the FPGA wrapper. Consumes the 8-bit classifier result (uo_out) and

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_tick_gen.sv | 33 +++
 rtl/seg_result_scanner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment decoder for the result scanner.
package seg_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF    = 4'hF;

  // Decode one nibble into its segment pattern.
  function automatic logic [SEG_W-1:0] hex2seg(input logic [NIB_W-1:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Digit-slot timer: counts DIV cycles per slot and flags the anti-ghosting window.
module seg_tick_gen #(
  parameter int unsigned DIV       = 100_000,
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_wrap_c_o,
  output logic in_guard_c_o
);

  localparam int unsigned SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  // Wrap at the last cycle of the slot; guard covers the first GUARD_CYC cycles.
  always_comb begin
    slot_wrap_c_o = (slot_q == SLOT_W'(DIV - 1));
    in_guard_c_o  = (slot_q < SLOT_W'(GUARD_CYC));
    slot_d        = slot_wrap_c_o ? '0 : slot_q + SLOT_W'(1);
  end

  // Slot counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/seg_result_scanner.sv
// Drives the 4-digit multiplexed display: result in hex on digits 1:0,
// saturating change count on digits 3:2, digit-0 dp flashes after each change.
module seg_result_scanner
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned REFRESH_HZ    = 1000,
  parameter int unsigned GUARD_CYC     = 16,
  parameter int unsigned FLASH_MS      = 250,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned DIV       = CLK_HZ / REFRESH_HZ;
  localparam int unsigned FLASH_CYC = CLK_HZ / 1000 * FLASH_MS;
  localparam int unsigned FLASH_W   = $clog2(FLASH_CYC + 1);

  logic               slot_wrap_c;
  logic               in_guard_c;

  logic [7:0]         result_q;
  logic [7:0]         chg_cnt_q,   chg_cnt_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [1:0]         idx_q,       idx_d;
  logic [AN_W-1:0]    an_q,        an_d;
  logic [SEG_W-1:0]   seg_q,       seg_d;
  logic               dp_q,        dp_d;

  logic               change_c;
  logic [NIB_W-1:0]   nib_c;
  logic               lead_blank_c;

  seg_tick_gen #(
    .DIV       (DIV),
    .GUARD_CYC (GUARD_CYC)
  ) u_tick (
    .clk           (clk),
    .rst_n         (rst_n),
    .slot_wrap_c_o (slot_wrap_c),
    .in_guard_c_o  (in_guard_c)
  );

  // Next-state for the counters and the registered display pins.
  always_comb begin
    change_c     = (result != result_q);
    chg_cnt_d    = chg_cnt_q;
    flash_cnt_d  = flash_cnt_q;
    idx_d        = idx_q;
    nib_c        = result_q[3:0];
    lead_blank_c = 1'b0;
    an_d         = AN_OFF;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;

    if (change_c && (chg_cnt_q != 8'hFF)) begin
      chg_cnt_d = chg_cnt_q + 8'd1;
    end

    if (change_c) begin
      flash_cnt_d = FLASH_W'(FLASH_CYC);
    end else if (flash_cnt_q != '0) begin
      flash_cnt_d = flash_cnt_q - FLASH_W'(1);
    end

    if (slot_wrap_c) begin
      idx_d = idx_q + 2'd1;
    end

    case (idx_q)
      2'd0:    nib_c = result_q[3:0];
      2'd1:    nib_c = result_q[7:4];
      2'd2:    nib_c = chg_cnt_q[3:0];
      default: nib_c = chg_cnt_q[7:4];
    endcase

    // Odd digits are the high nibbles, so a zero there is a leading zero.
    lead_blank_c = (BLANK_LEADING != 0) && idx_q[0] && (nib_c == 4'h0);

    if (!in_guard_c) begin
      an_d  = ~(AN_W'(1) << idx_q);
      seg_d = lead_blank_c ? SEG_BLANK : hex2seg(nib_c);
      dp_d  = !((idx_q == 2'd0) && (flash_cnt_q != '0));
    end
  end

  // Capture, counter and scan-index state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      chg_cnt_q   <= '0;
      flash_cnt_q <= '0;
      idx_q       <= '0;
    end else begin
      result_q    <= result;
      chg_cnt_q   <= chg_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      idx_q       <= idx_d;
    end
  end

  // Output pin registers, blank in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
